// File: rtl/snowman_draw_ctrl.sv
// snowman_draw_ctrl: scans the snowman sprite ROM and turns each word into a clipped framebuffer plot.
module snowman_draw_ctrl #(
  parameter int SPRITE_WORDS = 840,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [7:0]  x_coord,
  input  logic [6:0]  y_coord,
  input  logic [15:0] sprite_data,
  output logic [9:0]  addr_read,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        writeEn,
  output logic        frame_done
);
  logic [7:0] org_x;
  logic [6:0] org_y;
  logic       cap, last, unused_bits;
  logic [7:0] eff_x;
  logic [6:0] eff_y;
  logic [8:0] sum_x;
  logic [7:0] sum_y;
  // the first word of a frame uses the incoming origin before it is latched
  assign cap = enable && addr_read == '0;
  assign last = addr_read == 10'(SPRITE_WORDS - 1);
  assign eff_x = cap ? x_coord : org_x;
  assign eff_y = cap ? y_coord : org_y;
  assign sum_x = {1'b0, eff_x} + {4'b0, sprite_data[15:11]};
  assign sum_y = {1'b0, eff_y} + {3'b0, sprite_data[10:6]};
  assign unused_bits = ^sprite_data[2:1];
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_read <= '0;
      org_x <= '0;
      org_y <= '0;
      x <= '0;
      y <= '0;
      colour <= '0;
      writeEn <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      if (enable) addr_read <= last ? '0 : addr_read + 10'd1;
      if (cap) begin
        org_x <= x_coord;
        org_y <= y_coord;
      end
      x <= sum_x[7:0];
      y <= sum_y[6:0];
      colour <= sprite_data[5:3];
      writeEn <= enable && sprite_data[0] && sum_x < 9'(SCREEN_W) && sum_y < 8'(SCREEN_H);
      frame_done <= enable && last;
    end
  end
endmodule

// File: tb/tb_snowman_draw_ctrl.sv
// tb_snowman_draw_ctrl: directed and random scan of a ROM image against a pixel-level reference model.
module tb_snowman_draw_ctrl;
  logic        clock = 0, reset = 1, enable = 0;
  logic [7:0]  x_coord = 0;
  logic [6:0]  y_coord = 0;
  logic [15:0] sprite_data;
  logic [9:0]  addr_read;
  logic [7:0]  x;
  logic [6:0]  y;
  logic [2:0]  colour;
  logic        writeEn, frame_done;
  logic [15:0] rom [840];
  int tests = 0, fails = 0;
  int ma = 0, mox = 0, moy = 0, ncyc = 0;

  snowman_draw_ctrl dut (
    .clock(clock), .reset(reset), .enable(enable), .x_coord(x_coord), .y_coord(y_coord),
    .sprite_data(sprite_data), .addr_read(addr_read), .x(x), .y(y), .colour(colour),
    .writeEn(writeEn), .frame_done(frame_done)
  );

  assign sprite_data = rom[addr_read];
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one clock: predict the pixel from the spec rules, then compare after the edge
  task automatic step(input logic en, input logic rst);
    logic [15:0] w;
    int xs, ys, ex, ey, ec, ew, efd;
    logic full;
    enable = en;
    reset = rst;
    ex = 0; ey = 0; ec = 0; ew = 0; efd = 0; full = 1;
    if (rst) begin
      ma = 0; mox = 0; moy = 0; ncyc = 0;
    end else if (en) begin
      w = rom[ma];
      if (ma == 0) begin
        mox = int'(x_coord);
        moy = int'(y_coord);
      end
      xs = mox + int'(w[15:11]);
      ys = moy + int'(w[10:6]);
      ex = xs % 256;
      ey = ys % 128;
      ec = int'(w[5:3]);
      ew = (w[0] && xs < 160 && ys < 120) ? 1 : 0;
      efd = (ma == 839) ? 1 : 0;
      ma = (ma + 1) % 840;
      ncyc++;
    end else full = 0;
    @(posedge clock);
    #1;
    chk("addr", 32'(addr_read), ma);
    chk("we", 32'(writeEn), ew);
    chk("fd", 32'(frame_done), efd);
    if (full) begin
      chk("x", 32'(x), ex);
      chk("y", 32'(y), ey);
      chk("colour", 32'(colour), ec);
    end
  endtask

  task automatic run_to(input int target);
    while (ma != target) step(1, 0);
  endtask

  initial begin
    for (int i = 0; i < 840; i++)
      rom[i] = {5'($urandom_range(0, 27)), 5'($urandom_range(0, 29)), 3'($urandom), 2'($urandom), 1'($urandom)};
    rom[0]   = {5'd0, 5'd0, 3'd2, 2'd0, 1'b1};
    rom[4]   = {5'd1, 5'd1, 3'd1, 2'b11, 1'b1};
    rom[5]   = {5'd2, 5'd2, 3'd3, 2'b00, 1'b0};
    rom[6]   = {5'd3, 5'd3, 3'd4, 2'b10, 1'b1};
    rom[10]  = {5'd12, 5'd5, 3'd4, 2'd0, 1'b1};
    rom[11]  = {5'd9, 5'd19, 3'd5, 2'd0, 1'b1};
    rom[12]  = {5'd0, 5'd10, 3'd6, 2'd0, 1'b1};
    rom[839] = {5'd27, 5'd29, 3'b111, 2'd0, 1'b1};
    #1;
    step(0, 1);
    step(1, 1);
    step(0, 0);
    x_coord = 10; y_coord = 20;
    run_to(4);
    step(1, 0); chk("tp4_we", 32'(writeEn), 1);
    step(1, 0); chk("tp5_we", 32'(writeEn), 0);
    step(1, 0); chk("tp6_we", 32'(writeEn), 1);
    run_to(400);
    x_coord = 50;
    run_to(839);
    step(1, 0);
    chk("done_cycles", ncyc, 840);
    chk("done_fd", 32'(frame_done), 1);
    chk("done_x", 32'(x), 37);
    chk("done_y", 32'(y), 49);
    chk("done_col", 32'(colour), 7);
    chk("done_we", 32'(writeEn), 1);
    chk("done_addr", 32'(addr_read), 0);
    step(1, 0); chk("new_origin_x", 32'(x), 50);
    run_to(200);
    for (int i = 0; i < 3; i++) begin
      step(0, 0);
      chk("stall_addr", 32'(addr_read), 200);
      chk("stall_we", 32'(writeEn), 0);
    end
    ncyc = 0;
    run_to(839);
    step(1, 0); chk("slip_fd", 32'(frame_done), 1);
    chk("slip_cycles", ncyc, 640);
    x_coord = 150; y_coord = 100;
    run_to(10);
    step(1, 0); chk("clip_x_we", 32'(writeEn), 0);
    step(1, 0);
    chk("edge_x", 32'(x), 159);
    chk("edge_y", 32'(y), 119);
    chk("edge_we", 32'(writeEn), 1);
    run_to(839);
    step(1, 0);
    x_coord = 0; y_coord = 120;
    run_to(12);
    step(1, 0); chk("clip_y_we", 32'(writeEn), 0);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        x_coord = 8'($urandom);
        y_coord = 7'($urandom);
      end
      step($urandom_range(0, 3) != 0, 0);
    end
    run_to(500);
    x_coord = 33; y_coord = 44;
    step(1, 1);
    chk("rst_addr", 32'(addr_read), 0);
    chk("rst_x", 32'(x), 0);
    step(1, 0);
    chk("rel_addr", 32'(addr_read), 1);
    chk("rel_x", 32'(x), 33);
    chk("rel_y", 32'(y), 44);
    for (int i = 0; i < 300; i++) step($urandom_range(0, 3) != 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
